// File: rtl/sm83_irq_dispatch.sv
// Interrupt sequencer for the sm83 core: IME with delayed EI, HALT wake-up,
// late fixed-priority arbitration and the 5 M-cycle dispatch pseudo-instruction.
module sm83_irq_dispatch #(
  parameter int unsigned NUM_IRQS   = 8,
  parameter int unsigned ADR_WIDTH  = 16,
  parameter int unsigned VEC_BASE   = 'h40,
  parameter int unsigned VEC_STRIDE = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 mcyc_end,
  input  logic                 instr_end,
  input  logic [NUM_IRQS-1:0]  irq,
  input  logic                 ei,
  input  logic                 di,
  input  logic                 reti,
  input  logic                 halt,
  output logic                 ime,
  output logic                 halted,
  output logic                 int_take,
  output logic                 dispatch,
  output logic [2:0]           disp_m,
  output logic [NUM_IRQS-1:0]  iack,
  output logic [ADR_WIDTH-1:0] vector
);

  localparam int unsigned IDX_W = (NUM_IRQS > 1) ? $clog2(NUM_IRQS) : 1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    D0   = 3'd1,
    D1   = 3'd2,
    D2   = 3'd3,
    D3   = 3'd4,
    D4   = 3'd5
  } state_t;

  state_t               state, state_next;
  logic [2:0]           disp_m_next;
  logic                 take_start;
  logic                 arb_now;
  logic                 ei_pend;
  logic                 bnd;
  logic                 any_irq;
  logic                 arb_hit;
  logic [IDX_W-1:0]     arb_idx;
  logic [ADR_WIDTH-1:0] arb_vec;
  logic [NUM_IRQS-1:0]  arb_onehot;

  assign bnd      = mcyc_end & instr_end;
  assign any_irq  = |irq;
  // ei_pend blocks the take so the instruction after EI always runs first
  assign int_take = ime & any_irq & ~dispatch & ~ei_pend;

  // state register; dispatch and disp_m are registered copies of the next state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      dispatch <= 1'b0;
      disp_m   <= 3'd0;
    end else begin
      state    <= state_next;
      dispatch <= (state_next != IDLE);
      disp_m   <= disp_m_next;
    end
  end

  // next-state logic
  always_comb begin
    state_next  = state;
    take_start  = 1'b0;
    arb_now     = 1'b0;
    disp_m_next = 3'd0;
    case (state)
      IDLE: if (bnd && int_take) begin
        state_next = D0;
        take_start = 1'b1;
      end
      D0: if (mcyc_end) state_next = D1;
      D1: if (mcyc_end) state_next = D2;
      D2: if (mcyc_end) state_next = D3;
      D3: if (mcyc_end) begin
        state_next = D4;
        arb_now    = 1'b1;
      end
      D4: if (mcyc_end) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (state_next != IDLE) disp_m_next = 3'(state_next) - 3'd1;
  end

  // IME and the one-boundary EI delay
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ime     <= 1'b0;
      ei_pend <= 1'b0;
    end else if (di || take_start) begin
      ime     <= 1'b0;
      ei_pend <= 1'b0;
    end else begin
      if (reti) ime <= 1'b1;
      if (ei) begin
        ei_pend <= 1'b1;
      end else if (bnd && ei_pend) begin
        ime     <= 1'b1;
        ei_pend <= 1'b0;
      end
    end
  end

  // HALT is entered only with no request pending; any request wakes the core
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      halted <= 1'b0;
    end else if (halt && !any_irq) begin
      halted <= 1'b1;
    end else if (any_irq) begin
      halted <= 1'b0;
    end
  end

  // lowest set request bit wins
  always_comb begin
    arb_hit = 1'b0;
    arb_idx = '0;
    for (int i = NUM_IRQS - 1; i >= 0; i--) begin
      if (irq[i]) begin
        arb_hit = 1'b1;
        arb_idx = IDX_W'(i);
      end
    end
    arb_vec    = ADR_WIDTH'(VEC_BASE + 32'(arb_idx) * VEC_STRIDE);
    arb_onehot = NUM_IRQS'(1) << arb_idx;
  end

  // late arbitration at D4 entry; a cancelled request yields vector 0 and no ack
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      iack   <= '0;
      vector <= '0;
    end else begin
      iack <= '0;
      if (arb_now) begin
        if (arb_hit) begin
          iack   <= arb_onehot;
          vector <= arb_vec;
        end else begin
          vector <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_sm83_irq_dispatch.sv
// Self-checking bench for sm83_irq_dispatch: clock-by-clock vector table fed
// through a scoreboard queue, plus a hand-written reset-during-dispatch sequence.
module tb_sm83_irq_dispatch;

  logic        clk = 1'b0;
  logic        reset;
  logic        mcyc_end, instr_end, ei, di, reti, halt;
  logic [7:0]  irq;
  logic        ime, halted, int_take, dispatch;
  logic [2:0]  disp_m;
  logic [7:0]  iack;
  logic [15:0] vector;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        me, ie;
    logic [7:0]  irq;
    logic        ei, di, reti, halt;
    logic        x_ime, x_halted, x_disp;
    logic [2:0]  x_m;
    logic [7:0]  x_iack;
    logic [15:0] x_vec;
    logic        x_take;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   sb_row[$];

  sm83_irq_dispatch dut (
    .clk(clk), .reset(reset), .mcyc_end(mcyc_end), .instr_end(instr_end),
    .irq(irq), .ei(ei), .di(di), .reti(reti), .halt(halt),
    .ime(ime), .halted(halted), .int_take(int_take), .dispatch(dispatch),
    .disp_m(disp_m), .iack(iack), .vector(vector)
  );

  always #5 clk = ~clk;

  // counts every iack pulse; cleared by the bench when reset is applied
  int iack_pulses = 0;
  always @(posedge clk) if (iack != 8'h00) iack_pulses <= iack_pulses + 1;

  task automatic chk(input string nm, input int row, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %h expected %h", nm, row, act, exp);
    end
  endtask

  task automatic add(input logic me, input logic ie, input logic [7:0] q,
                     input logic e, input logic d, input logic r, input logic h,
                     input logic x_ime, input logic x_halted, input logic x_disp,
                     input logic [2:0] x_m, input logic [7:0] x_iack,
                     input logic [15:0] x_vec, input logic x_take);
    vec_t v;
    v.me = me; v.ie = ie; v.irq = q; v.ei = e; v.di = d; v.reti = r; v.halt = h;
    v.x_ime = x_ime; v.x_halted = x_halted; v.x_disp = x_disp; v.x_m = x_m;
    v.x_iack = x_iack; v.x_vec = x_vec; v.x_take = x_take;
    tbl.push_back(v);
  endtask

  task automatic drive(input logic me, input logic ie, input logic [7:0] q,
                       input logic e, input logic d, input logic r, input logic h);
    mcyc_end = me; instr_end = ie; irq = q; ei = e; di = d; reti = r; halt = h;
  endtask

  initial begin
    vec_t x;
    int   row;

    reset = 1'b1;
    drive(0, 0, 8'h00, 0, 0, 0, 0);

    //   me ie irq   ei di rt ht | ime hlt dsp m  iack   vec      take
    // reti, irq bit 2, full dispatch with multi-clock M-cycles
    add(0, 0, 8'h00, 0, 0, 1, 0,  1, 0, 0, 3'd0, 8'h00, 16'h0000, 0);
    add(1, 1, 8'h04, 0, 0, 0, 0,  0, 0, 1, 3'd0, 8'h00, 16'h0000, 0);
    add(0, 0, 8'h04, 0, 0, 0, 0,  0, 0, 1, 3'd0, 8'h00, 16'h0000, 0);
    add(1, 0, 8'h04, 0, 0, 0, 0,  0, 0, 1, 3'd1, 8'h00, 16'h0000, 0);
    add(1, 0, 8'h04, 0, 0, 0, 0,  0, 0, 1, 3'd2, 8'h00, 16'h0000, 0);
    add(1, 0, 8'h04, 0, 0, 0, 0,  0, 0, 1, 3'd3, 8'h00, 16'h0000, 0);
    add(0, 0, 8'h04, 0, 0, 0, 0,  0, 0, 1, 3'd3, 8'h00, 16'h0000, 0);
    add(1, 0, 8'h04, 0, 0, 0, 0,  0, 0, 1, 3'd4, 8'h04, 16'h0050, 0);
    add(0, 0, 8'h04, 0, 0, 0, 0,  0, 0, 1, 3'd4, 8'h00, 16'h0050, 0);
    add(1, 0, 8'h04, 0, 0, 0, 0,  0, 0, 0, 3'd0, 8'h00, 16'h0050, 0);
    // EI at bnd k, ime at bnd k+1, dispatch at bnd k+2
    add(1, 1, 8'h01, 1, 0, 0, 0,  0, 0, 0, 3'd0, 8'h00, 16'h0050, 0);
    add(1, 0, 8'h01, 0, 0, 0, 0,  0, 0, 0, 3'd0, 8'h00, 16'h0050, 0);
    add(1, 1, 8'h01, 0, 0, 0, 0,  1, 0, 0, 3'd0, 8'h00, 16'h0050, 1);
    add(1, 0, 8'h01, 0, 0, 0, 0,  1, 0, 0, 3'd0, 8'h00, 16'h0050, 1);
    add(1, 1, 8'h01, 0, 0, 0, 0,  0, 0, 1, 3'd0, 8'h00, 16'h0050, 0);
    add(1, 0, 8'h01, 0, 0, 0, 0,  0, 0, 1, 3'd1, 8'h00, 16'h0050, 0);
    add(1, 0, 8'h01, 0, 0, 0, 0,  0, 0, 1, 3'd2, 8'h00, 16'h0050, 0);
    add(1, 0, 8'h01, 0, 0, 0, 0,  0, 0, 1, 3'd3, 8'h00, 16'h0050, 0);
    add(1, 0, 8'h01, 0, 0, 0, 0,  0, 0, 1, 3'd4, 8'h01, 16'h0040, 0);
    add(1, 0, 8'h01, 0, 0, 0, 0,  0, 0, 0, 3'd0, 8'h00, 16'h0040, 0);
    // EI;DI and simultaneous EI+DI leave ime off
    add(1, 1, 8'h01, 1, 0, 0, 0,  0, 0, 0, 3'd0, 8'h00, 16'h0040, 0);
    add(0, 0, 8'h01, 0, 1, 0, 0,  0, 0, 0, 3'd0, 8'h00, 16'h0040, 0);
    add(1, 1, 8'h01, 0, 0, 0, 0,  0, 0, 0, 3'd0, 8'h00, 16'h0040, 0);
    add(1, 1, 8'h01, 1, 1, 0, 0,  0, 0, 0, 3'd0, 8'h00, 16'h0040, 0);
    add(1, 1, 8'h01, 0, 0, 0, 0,  0, 0, 0, 3'd0, 8'h00, 16'h0040, 0);
    // request cancelled before D4
    add(0, 0, 8'h00, 0, 0, 1, 0,  1, 0, 0, 3'd0, 8'h00, 16'h0040, 0);
    add(1, 1, 8'h01, 0, 0, 0, 0,  0, 0, 1, 3'd0, 8'h00, 16'h0040, 0);
    add(1, 0, 8'h11, 0, 0, 0, 0,  0, 0, 1, 3'd1, 8'h00, 16'h0040, 0);
    add(1, 0, 8'h00, 0, 0, 0, 0,  0, 0, 1, 3'd2, 8'h00, 16'h0040, 0);
    add(1, 0, 8'h00, 0, 0, 0, 0,  0, 0, 1, 3'd3, 8'h00, 16'h0040, 0);
    add(1, 0, 8'h00, 0, 0, 0, 0,  0, 0, 1, 3'd4, 8'h00, 16'h0000, 0);
    add(1, 0, 8'h00, 0, 0, 0, 0,  0, 0, 0, 3'd0, 8'h00, 16'h0000, 0);
    // request changes 'b1000 -> 'b0010 mid-dispatch
    add(0, 0, 8'h00, 0, 0, 1, 0,  1, 0, 0, 3'd0, 8'h00, 16'h0000, 0);
    add(1, 1, 8'h08, 0, 0, 0, 0,  0, 0, 1, 3'd0, 8'h00, 16'h0000, 0);
    add(1, 0, 8'h08, 0, 0, 0, 0,  0, 0, 1, 3'd1, 8'h00, 16'h0000, 0);
    add(1, 0, 8'h02, 0, 0, 0, 0,  0, 0, 1, 3'd2, 8'h00, 16'h0000, 0);
    add(1, 0, 8'h02, 0, 0, 0, 0,  0, 0, 1, 3'd3, 8'h00, 16'h0000, 0);
    add(1, 0, 8'h02, 0, 0, 0, 0,  0, 0, 1, 3'd4, 8'h02, 16'h0048, 0);
    add(1, 0, 8'h00, 0, 0, 0, 0,  0, 0, 0, 3'd0, 8'h00, 16'h0048, 0);
    // upper request bits: 'hC0 resolves to bit 6
    add(0, 0, 8'h00, 0, 0, 1, 0,  1, 0, 0, 3'd0, 8'h00, 16'h0048, 0);
    add(1, 1, 8'hC0, 0, 0, 0, 0,  0, 0, 1, 3'd0, 8'h00, 16'h0048, 0);
    add(1, 0, 8'hC0, 0, 0, 0, 0,  0, 0, 1, 3'd1, 8'h00, 16'h0048, 0);
    add(1, 0, 8'hC0, 0, 0, 0, 0,  0, 0, 1, 3'd2, 8'h00, 16'h0048, 0);
    add(1, 0, 8'hC0, 0, 0, 0, 0,  0, 0, 1, 3'd3, 8'h00, 16'h0048, 0);
    add(1, 0, 8'hC0, 0, 0, 0, 0,  0, 0, 1, 3'd4, 8'h40, 16'h0070, 0);
    add(1, 0, 8'h00, 0, 0, 0, 0,  0, 0, 0, 3'd0, 8'h00, 16'h0070, 0);
    // HALT with ime=0: wake without dispatch; HALT with irq pending never halts
    add(1, 1, 8'h00, 0, 0, 0, 1,  0, 1, 0, 3'd0, 8'h00, 16'h0070, 0);
    add(1, 1, 8'h00, 0, 0, 0, 0,  0, 1, 0, 3'd0, 8'h00, 16'h0070, 0);
    add(0, 0, 8'h01, 0, 0, 0, 0,  0, 0, 0, 3'd0, 8'h00, 16'h0070, 0);
    add(1, 1, 8'h01, 0, 0, 0, 0,  0, 0, 0, 3'd0, 8'h00, 16'h0070, 0);
    add(0, 0, 8'h01, 0, 0, 0, 1,  0, 0, 0, 3'd0, 8'h00, 16'h0070, 0);
    // HALT with ime=1: wake then dispatch at next bnd
    add(0, 0, 8'h00, 0, 0, 1, 0,  1, 0, 0, 3'd0, 8'h00, 16'h0070, 0);
    add(1, 1, 8'h00, 0, 0, 0, 1,  1, 1, 0, 3'd0, 8'h00, 16'h0070, 0);
    add(0, 0, 8'h01, 0, 0, 0, 0,  1, 0, 0, 3'd0, 8'h00, 16'h0070, 1);
    add(1, 1, 8'h01, 0, 0, 0, 0,  0, 0, 1, 3'd0, 8'h00, 16'h0070, 0);
    add(1, 0, 8'h01, 0, 0, 0, 0,  0, 0, 1, 3'd1, 8'h00, 16'h0070, 0);
    add(1, 0, 8'h01, 0, 0, 0, 0,  0, 0, 1, 3'd2, 8'h00, 16'h0070, 0);
    add(1, 0, 8'h01, 0, 0, 0, 0,  0, 0, 1, 3'd3, 8'h00, 16'h0070, 0);
    add(1, 0, 8'h01, 0, 0, 0, 0,  0, 0, 1, 3'd4, 8'h01, 16'h0040, 0);
    add(1, 0, 8'h00, 0, 0, 0, 0,  0, 0, 0, 3'd0, 8'h00, 16'h0040, 0);

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ime", -1, 16'(ime), 16'h0);
    chk("rst_halted", -1, 16'(halted), 16'h0);
    chk("rst_dispatch", -1, 16'(dispatch), 16'h0);
    chk("rst_disp_m", -1, 16'(disp_m), 16'h0);
    chk("rst_iack", -1, 16'(iack), 16'h0);
    chk("rst_vector", -1, vector, 16'h0);
    chk("rst_int_take", -1, 16'(int_take), 16'h0);
    @(negedge clk);
    reset = 1'b0;

    // table through the scoreboard
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      drive(tbl[i].me, tbl[i].ie, tbl[i].irq, tbl[i].ei, tbl[i].di, tbl[i].reti, tbl[i].halt);
      sb.push_back(tbl[i]);
      sb_row.push_back(i);
      @(posedge clk);
      #1;
      x   = sb.pop_front();
      row = sb_row.pop_front();
      chk("ime", row, 16'(ime), 16'(x.x_ime));
      chk("halted", row, 16'(halted), 16'(x.x_halted));
      chk("dispatch", row, 16'(dispatch), 16'(x.x_disp));
      chk("disp_m", row, 16'(disp_m), 16'(x.x_m));
      chk("iack", row, 16'(iack), 16'(x.x_iack));
      chk("vector", row, vector, x.x_vec);
      chk("int_take", row, 16'(int_take), 16'(x.x_take));
    end
    chk("sb_empty", -1, 16'(sb.size()), 16'h0);

    // reset asserted during D2
    @(negedge clk); drive(0, 0, 8'h00, 0, 0, 1, 0);
    @(negedge clk); drive(1, 1, 8'h04, 0, 0, 0, 0);
    @(negedge clk); drive(1, 0, 8'h04, 0, 0, 0, 0);
    @(negedge clk); drive(1, 0, 8'h04, 0, 0, 0, 0);
    @(negedge clk);
    drive(0, 0, 8'h04, 0, 0, 0, 0);
    chk("pre_rst_disp_m", -1, 16'(disp_m), 16'h2);
    #2;
    reset = 1'b1;
    iack_pulses = 0;
    #1;
    chk("mid_rst_dispatch", -1, 16'(dispatch), 16'h0);
    chk("mid_rst_disp_m", -1, 16'(disp_m), 16'h0);
    chk("mid_rst_ime", -1, 16'(ime), 16'h0);
    chk("mid_rst_vector", -1, vector, 16'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drive(1'(i % 2), 1'(i % 2), 8'h04, 0, 0, 0, 0);
    end
    @(negedge clk);
    chk("post_rst_iack_pulses", -1, 16'(iack_pulses), 16'h0);
    chk("post_rst_dispatch", -1, 16'(dispatch), 16'h0);
    chk("post_rst_vector", -1, vector, 16'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
